// File: rtl/mux_capture_fifo_if.sv
// Capture-side stream bundle for mux_capture_fifo.
// Upstream mux output in, tagged FIFO head out.
interface mux_capture_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int SEL_WIDTH  = 4
);
  logic [DATA_WIDTH-1:0] in_data;
  logic [SEL_WIDTH-1:0]  in_sel;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic [SEL_WIDTH-1:0]  out_sel;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output in_data,
    output in_sel,
    output in_valid,
    output out_ready,
    input  out_data,
    input  out_sel,
    input  out_valid
  );

  modport slave (
    input  in_data,
    input  in_sel,
    input  in_valid,
    input  out_ready,
    output out_data,
    output out_sel,
    output out_valid
  );
endinterface

// File: rtl/mux_capture_fifo.sv
// Captures tagged port-mux output into a FIFO.
// Drops illegal tags and overflows with sticky flags.
module mux_capture_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int SEL_WIDTH  = 4,
  parameter int DEPTH      = 8,
  parameter int NUM_PORTS  = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  mux_capture_fifo_if.slave            bus,
  input  logic                         clr_flags,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         overflow,
  output logic                         bad_sel
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef logic [PW-1:0] ptr_t;

  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic [SEL_WIDTH-1:0]  mem_sel  [DEPTH];

  ptr_t wr_ptr;
  ptr_t rd_ptr;
  logic legal;
  logic pop;
  logic push;
  logic ovf_ev;
  logic bad_ev;

  function automatic ptr_t inc(ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  assign legal  = 32'(bus.in_sel) < NUM_PORTS;
  assign pop    = bus.out_valid && bus.out_ready;
  assign push   = bus.in_valid && legal && (!full || pop);
  assign ovf_ev = bus.in_valid && legal && full && !pop;
  assign bad_ev = bus.in_valid && !legal;

  assign bus.out_valid = (count != '0);
  assign full          = (count == CW'(DEPTH));
  assign bus.out_data  = mem_data[rd_ptr];
  assign bus.out_sel   = mem_sel[rd_ptr];

  // storage write, left unreset
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= bus.in_data;
      mem_sel[wr_ptr]  <= bus.in_sel;
    end
  end

  // pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= inc(wr_ptr);
      if (pop)  rd_ptr <= inc(rd_ptr);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // sticky flags, a new event beats clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      bad_sel  <= 1'b0;
    end else begin
      overflow <= ovf_ev | (overflow & ~clr_flags);
      bad_sel  <= bad_ev | (bad_sel & ~clr_flags);
    end
  end
endmodule

// File: doc/mux_capture_fifo.md
MUX_CAPTURE_FIFO -- requirements
Module: mux_capture_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL be the width of captured mux data.
REQ-002 Parameter SEL_WIDTH, default 4, SHALL be the width of the captured source-port tag.
REQ-003 Parameter DEPTH, default 8, SHALL be the number of entries; legal range 2..64, need not be a power of two.
REQ-004 Parameter NUM_PORTS, default 10, SHALL be the number of valid source ports; tags 0..NUM_PORTS-1 are legal.
REQ-005 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-007 in_data  input  DATA_WIDTH  SHALL carry the selected data from the upstream port mux (its mux_out).
REQ-008 in_sel  input  SEL_WIDTH  SHALL carry the port select that produced in_data, aligned to the same cycle.
REQ-009 in_valid  input  1  SHALL qualify in_data/in_sel (the upstream valid_out); there is no upstream backpressure.
REQ-010 out_data  output  DATA_WIDTH  SHALL be the head entry's data.
REQ-011 out_sel  output  SEL_WIDTH  SHALL be the head entry's port tag.
REQ-012 out_valid  output  1  SHALL be high when the FIFO holds at least one entry.
REQ-013 out_ready  input  1  SHALL be the downstream acceptance; pop occurs when out_valid && out_ready.
REQ-014 count  output  $clog2(DEPTH+1)  SHALL be the current occupancy.
REQ-015 full  output  1  SHALL be high when count == DEPTH.
REQ-016 overflow  output  1  SHALL be a sticky flag set when a valid input is dropped because the FIFO is full.
REQ-017 bad_sel  output  1  SHALL be a sticky flag set when in_valid is high with in_sel >= NUM_PORTS.
REQ-018 clr_flags  input  1  SHALL clear overflow and bad_sel synchronously when high.

Function
REQ-019 Push SHALL occur when in_valid, in_sel < NUM_PORTS, and (not full or pop in the same cycle).
REQ-020 Entries with in_sel >= NUM_PORTS SHALL be discarded (not stored) and SHALL set bad_sel on the next edge.
REQ-021 in_valid with legal in_sel while full and no pop SHALL be discarded and SHALL set overflow on the next edge; stored contents unchanged.
REQ-022 Simultaneous push and pop when full SHALL both succeed; count stays DEPTH, overflow unchanged.
REQ-023 Simultaneous push and pop at 0 < count < DEPTH SHALL leave count unchanged.
REQ-024 No fall-through: a push into an empty FIFO SHALL make out_valid high only after the capturing edge (latency 1 cycle in to out).
REQ-025 out_data/out_sel SHALL be driven from storage at the read pointer and remain stable while out_valid && !out_ready.
REQ-026 out_ready while empty SHALL have no effect.
REQ-027 Read and write pointers SHALL wrap from DEPTH-1 to 0.
REQ-028 Entries SHALL leave in strict arrival order with data and tag kept paired.
REQ-029 clr_flags coincident with a new overflow/bad_sel event SHALL leave the flag set (set wins).
REQ-030 count SHALL update as count + push - pop each edge.

Reset
REQ-031 On rst_n low, pointers and count SHALL clear immediately; out_valid=0, full=0, count=0, overflow=0, bad_sel=0.
REQ-032 Storage contents need not be reset; out_data/out_sel are don't-care while out_valid=0.
REQ-033 Reset mid-operation SHALL discard all stored entries; first push after release is the new head.
REQ-034 Pushes SHALL be ignored while rst_n is low.

Verification
REQ-035 Push (0xA5, sel 3) into empty, out_ready=0 -> next cycle out_valid=1, out_data=0xA5, out_sel=3, count=1.
REQ-036 Push 9 entries 0x01..0x09 (sel 0..8), out_ready=0, DEPTH=8 -> full=1, count=8, overflow=1; drain yields 0x01..0x08 in order.
REQ-037 Full FIFO, push 0x55 with out_ready=1 same cycle -> count stays 8, overflow stays 0, 0x55 emerges last.
REQ-038 in_valid=1, in_sel=12 -> nothing stored, count unchanged, bad_sel=1; clr_flags pulse -> bad_sel=0.
REQ-039 Continuous push/pop for 20 cycles -> pointers wrap, output sequence equals input sequence, count constant.
REQ-040 Assert rst_n low with count=5 -> out_valid=0, count=0 without a clock edge; next push appears as head.
